// File: rtl/mem_stage_pkg.sv
// Shared op encodings, default widths and counter width for the MEM stage.
`timescale 1ns/1ps
package mem_stage_pkg;

  localparam int DEF_WORD_LEN     = 16;
  localparam int DEF_ADDR_LEN     = 10;
  localparam int DEF_REG_ADDR_LEN = 3;
  localparam int PERF_CNT_LEN     = 16;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Reserved encoding behaves as an ALU pass, so only load/store need decoding.
  function automatic logic op_is_load(input logic [1:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic op_is_store(input logic [1:0] op);
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/mem_stage_perf.sv
// Saturating 16-bit counters of accepted loads and stores.
// Only instantiated when MEM_STAGE_PERF_EN is defined.
`timescale 1ns/1ps
module mem_stage_perf
  import mem_stage_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load_acc,
  input  logic                    i_store_acc,
  output logic [PERF_CNT_LEN-1:0] o_perf_loads,
  output logic [PERF_CNT_LEN-1:0] o_perf_stores
);

  logic [1:0]                   inc;
  logic [1:0][PERF_CNT_LEN-1:0] cnt_q;

  assign inc = {i_store_acc, i_load_acc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [PERF_CNT_LEN-1:0] cnt_reg;
      logic [PERF_CNT_LEN-1:0] cnt_next;

      // Sticks at all-ones instead of wrapping.
      always_comb begin
        cnt_next = cnt_reg;
        if (inc[gi] && (cnt_reg != '1)) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign o_perf_loads  = cnt_q[0];
  assign o_perf_stores = cnt_q[1];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives data memory, registers the MEM/WB slot.
// Optional perf counters enabled by defining MEM_STAGE_PERF_EN.
`timescale 1ns/1ps
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int p_WORD_LEN     = DEF_WORD_LEN,
  parameter int p_ADDR_LEN     = DEF_ADDR_LEN,
  parameter int p_REG_ADDR_LEN = DEF_REG_ADDR_LEN
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [1:0]                i_op,
  input  logic [p_WORD_LEN-1:0]     i_alu_result,
  input  logic [p_WORD_LEN-1:0]     i_store_data,
  input  logic [p_REG_ADDR_LEN-1:0] i_rd,
  input  logic                      i_rd_wr_en,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic                      o_ready,
  output logic [p_ADDR_LEN-1:0]     o_mem_addr,
  output logic                      o_mem_wr_en,
  output logic [p_WORD_LEN-1:0]     o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0]     i_mem_rd_data,
  output logic                      o_wb_valid,
  output logic [p_WORD_LEN-1:0]     o_wb_data,
  output logic [p_REG_ADDR_LEN-1:0] o_wb_rd,
  output logic                      o_wb_wr_en,
  output logic                      o_load_busy,
  output logic [p_REG_ADDR_LEN-1:0] o_load_rd
`ifdef MEM_STAGE_PERF_EN
 ,output logic [PERF_CNT_LEN-1:0]   o_perf_loads,
  output logic [PERF_CNT_LEN-1:0]   o_perf_stores
`endif
);

  logic is_load;
  logic is_store;
  logic slot_live;
  logic accept;

  assign is_load   = op_is_load(i_op);
  assign is_store  = op_is_store(i_op);
  assign slot_live = i_valid & ~i_flush;
  assign accept    = slot_live & ~i_stall;

  assign o_ready       = ~i_stall;
  assign o_mem_addr    = i_alu_result[p_ADDR_LEN-1:0];
  assign o_mem_wr_data = i_store_data;
  // Gated by reset so an in-flight store cannot land while reset is asserted.
  assign o_mem_wr_en   = i_rst_n & accept & is_store;
  assign o_load_busy   = i_valid & is_load;
  assign o_load_rd     = i_rd;

  logic                      wb_valid_reg, wb_valid_next;
  logic [p_WORD_LEN-1:0]     wb_data_reg,  wb_data_next;
  logic [p_REG_ADDR_LEN-1:0] wb_rd_reg,    wb_rd_next;
  logic                      wb_wr_en_reg, wb_wr_en_next;

  always_comb begin
    wb_valid_next = wb_valid_reg;
    wb_data_next  = wb_data_reg;
    wb_rd_next    = wb_rd_reg;
    wb_wr_en_next = wb_wr_en_reg;
    if (!i_stall) begin
      wb_valid_next = slot_live;
      wb_data_next  = is_load ? i_mem_rd_data : i_alu_result;
      wb_rd_next    = i_rd;
      // r0 is hard-wired zero in the register file, never target it.
      wb_wr_en_next = slot_live & i_rd_wr_en & ~is_store & (i_rd != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
      wb_rd_reg    <= '0;
      wb_wr_en_reg <= 1'b0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      wb_data_reg  <= wb_data_next;
      wb_rd_reg    <= wb_rd_next;
      wb_wr_en_reg <= wb_wr_en_next;
    end
  end

  assign o_wb_valid = wb_valid_reg;
  assign o_wb_data  = wb_data_reg;
  assign o_wb_rd    = wb_rd_reg;
  assign o_wb_wr_en = wb_wr_en_reg;

`ifdef MEM_STAGE_PERF_EN
  mem_stage_perf u_perf (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_load_acc    (accept & is_load),
    .i_store_acc   (accept & is_store),
    .o_perf_loads  (o_perf_loads),
    .o_perf_stores (o_perf_stores)
  );
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a negedge data memory and a reference model.
// Perf-counter checks are compiled in when MEM_STAGE_PERF_EN is defined.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int W = 16;
  localparam int A = 10;
  localparam int R = 3;
  localparam int DEPTH = 1 << A;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_valid;
  logic [1:0]   i_op;
  logic [W-1:0] i_alu_result;
  logic [W-1:0] i_store_data;
  logic [R-1:0] i_rd;
  logic         i_rd_wr_en;
  logic         i_stall;
  logic         i_flush;
  logic         o_ready;
  logic [A-1:0] o_mem_addr;
  logic         o_mem_wr_en;
  logic [W-1:0] o_mem_wr_data;
  logic [W-1:0] i_mem_rd_data;
  logic         o_wb_valid;
  logic [W-1:0] o_wb_data;
  logic [R-1:0] o_wb_rd;
  logic         o_wb_wr_en;
  logic         o_load_busy;
  logic [R-1:0] o_load_rd;
`ifdef MEM_STAGE_PERF_EN
  logic [15:0]  o_perf_loads;
  logic [15:0]  o_perf_stores;
`endif

  mem_stage dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_op          (i_op),
    .i_alu_result  (i_alu_result),
    .i_store_data  (i_store_data),
    .i_rd          (i_rd),
    .i_rd_wr_en    (i_rd_wr_en),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_ready       (o_ready),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (i_mem_rd_data),
    .o_wb_valid    (o_wb_valid),
    .o_wb_data     (o_wb_data),
    .o_wb_rd       (o_wb_rd),
    .o_wb_wr_en    (o_wb_wr_en),
    .o_load_busy   (o_load_busy),
    .o_load_rd     (o_load_rd)
`ifdef MEM_STAGE_PERF_EN
   ,.o_perf_loads  (o_perf_loads),
    .o_perf_stores (o_perf_stores)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Existing data memory: write and registered read both on the falling edge.
  logic [W-1:0] dmem [DEPTH];
  always @(negedge i_clk) begin
    if (o_mem_wr_en) dmem[o_mem_addr] <= o_mem_wr_data;
    i_mem_rd_data <= dmem[o_mem_addr];
  end

  // Reference model state.
  logic [W-1:0] m_mem [DEPTH];
  logic         exp_valid;
  logic [W-1:0] exp_data;
  logic [R-1:0] exp_rd;
  logic         exp_wr_en;
  int           m_loads;
  int           m_stores;
  int           checks = 0;
  int           errors = 0;
  bit           quiet = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [W-1:0] alu,
                        input logic [W-1:0] sd, input logic [R-1:0] rd, input logic we,
                        input logic st, input logic fl);
    i_valid = v; i_op = op; i_alu_result = alu; i_store_data = sd;
    i_rd = rd; i_rd_wr_en = we; i_stall = st; i_flush = fl;
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_data = '0; exp_rd = '0; exp_wr_en = 1'b0;
    m_loads = 0; m_stores = 0;
  endtask

  task automatic chk_wb(input string name);
    chk({name, ".wb_valid"}, 32'(o_wb_valid), 32'(exp_valid));
    chk({name, ".wb_data"},  32'(o_wb_data),  32'(exp_data));
    chk({name, ".wb_rd"},    32'(o_wb_rd),    32'(exp_rd));
    chk({name, ".wb_wr_en"}, 32'(o_wb_wr_en), 32'(exp_wr_en));
`ifdef MEM_STAGE_PERF_EN
    chk({name, ".perf_loads"},  32'(o_perf_loads),  32'((m_loads  > 65535) ? 65535 : m_loads));
    chk({name, ".perf_stores"}, 32'(o_perf_stores), 32'((m_stores > 65535) ? 65535 : m_stores));
`endif
  endtask

  // One transaction: check the combinational outputs, advance the model, clock, check MEM/WB.
  task automatic tick(input string name);
    int   addr;
    logic live;
    #1;
    addr = int'(i_alu_result) % DEPTH;
    live = i_valid && !i_flush && !i_stall;
    chk({name, ".mem_wr_en"},   32'(o_mem_wr_en),   32'(live && i_op == 2'd2));
    chk({name, ".mem_addr"},    32'(o_mem_addr),    32'(addr));
    chk({name, ".mem_wr_data"}, 32'(o_mem_wr_data), 32'(i_store_data));
    chk({name, ".ready"},       32'(o_ready),       32'(!i_stall));
    chk({name, ".load_busy"},   32'(o_load_busy),   32'(i_valid && i_op == 2'd1));
    chk({name, ".load_rd"},     32'(o_load_rd),     32'(i_rd));
    if (!i_stall) begin
      exp_valid = i_valid && !i_flush;
      exp_rd    = i_rd;
      exp_data  = (i_op == 2'd1) ? m_mem[addr] : i_alu_result;
      exp_wr_en = i_valid && !i_flush && i_rd_wr_en && i_op != 2'd2 && i_rd != 0;
      if (live && i_op == 2'd2) begin
        m_mem[addr] = i_store_data;
        m_stores++;
      end
      if (live && i_op == 2'd1) m_loads++;
    end
    @(posedge i_clk);
    #1;
    chk_wb(name);
    if (!quiet)
      $display("[%0t] %-12s v=%b op=%0d alu=%h sd=%h rd=%0d st=%b fl=%b -> wb v=%b d=%h rd=%0d we=%b",
               $time, name, i_valid, i_op, i_alu_result, i_store_data, i_rd, i_stall, i_flush,
               o_wb_valid, o_wb_data, o_wb_rd, o_wb_wr_en);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i] = '0;
      m_mem[i] = '0;
    end
    set_in(0, 2'd0, '0, '0, '0, 0, 0, 0);
    model_reset();
    #1 i_rst_n = 1'b0;
    #2;
    chk_wb("reset");
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Store then load to the same address with no bypass.
    set_in(1, 2'd2, 16'h0005, 16'hBEEF, 3'd0, 0, 0, 0); tick("st_beef");
    set_in(1, 2'd1, 16'h0005, 16'h0000, 3'd2, 1, 0, 0); tick("ld_beef");
    chk("ld_beef.spec_data", 32'(o_wb_data), 32'h0000BEEF);
    chk("ld_beef.spec_rd",   32'(o_wb_rd),   32'd2);
    chk("ld_beef.spec_we",   32'(o_wb_wr_en), 32'd1);

    // Upper address bits wrap.
    set_in(1, 2'd2, 16'h0005, 16'h1234, 3'd0, 0, 0, 0); tick("st_1234");
    set_in(1, 2'd1, 16'h0405, 16'h0000, 3'd3, 1, 0, 0); tick("ld_wrap");
    chk("ld_wrap.spec_data", 32'(o_wb_data), 32'h00001234);

    // Stalled store with data change before release.
    set_in(1, 2'd2, 16'h00A0, 16'h1111, 3'd0, 0, 1, 0); tick("st_stall1");
    tick("st_stall2");
    i_store_data = 16'h2222;                          tick("st_stall3");
    chk("stall.mem_untouched", 32'(dmem[10'h0A0]), 32'h0);
    i_stall = 1'b0;                                   tick("st_release");
    set_in(1, 2'd1, 16'h00A0, 16'h0000, 3'd1, 1, 0, 0); tick("ld_2222");
    chk("ld_2222.spec_data", 32'(o_wb_data), 32'h00002222);

    // ALU result targeting r0.
    set_in(1, 2'd0, 16'h7777, 16'h0000, 3'd0, 1, 0, 0); tick("alu_r0");
    chk("alu_r0.spec_valid", 32'(o_wb_valid), 32'd1);
    chk("alu_r0.spec_we",    32'(o_wb_wr_en), 32'd0);

    // Flushed store, then flushed+stalled store.
    set_in(1, 2'd2, 16'h0005, 16'h5555, 3'd0, 0, 0, 1); tick("st_flush");
    chk("st_flush.spec_valid", 32'(o_wb_valid), 32'd0);
    set_in(1, 2'd2, 16'h0005, 16'h6666, 3'd4, 1, 1, 1); tick("st_fl_stall");
    i_stall = 1'b0;                                     tick("st_fl_rel");
    set_in(1, 2'd1, 16'h0005, 16'h0000, 3'd5, 1, 0, 0); tick("ld_after_fl");
    chk("ld_after_fl.spec_data", 32'(o_wb_data), 32'h00001234);

    // Reset pulsed low mid-cycle during a store.
    set_in(1, 2'd2, 16'h0005, 16'h9999, 3'd6, 1, 0, 0);
    #1 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.mem_wr_en", 32'(o_mem_wr_en), 32'd0);
    chk_wb("rst_mid");
    #5;
    set_in(0, 2'd0, '0, '0, '0, 0, 0, 0);
    i_rst_n = 1'b1;
    tick("rst_release");
    set_in(1, 2'd1, 16'h0005, 16'h0000, 3'd7, 1, 0, 0); tick("ld_after_rst");
    chk("ld_after_rst.spec_data", 32'(o_wb_data), 32'h00001234);

    // Randomized traffic on a small address window with random upper bits.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] alu;
      alu = (16'($urandom()) & 16'hFC00) | 16'($urandom_range(0, 15));
      set_in($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), alu, 16'($urandom()),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
      tick($sformatf("rnd%0d", n));
    end

`ifdef MEM_STAGE_PERF_EN
    // Saturation of the load counter.
    quiet = 1'b1;
    for (int n = 0; n < 70000; n++) begin
      set_in(1, 2'd1, 16'(n % 64), '0, 3'd1, 1, 0, 0);
      tick("perf_ld");
    end
    quiet = 1'b0;
    $display("[%0t] perf_sat     loads=%h stores=%h", $time, o_perf_loads, o_perf_stores);
    chk("perf_sat.spec_loads", 32'(o_perf_loads), 32'h0000FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
